// File: rtl/keypad_emu.sv
// Keypad matrix emulator: presses one key for a commanded number of scanner
// frames, aligned to frame starts, with a post-release gap and a scan watchdog.
module keypad_emu #(
    parameter int GAP_FRAMES = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] KB_Col,
    output logic [3:0] KB_Row,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_key,
    input  logic [7:0] cmd_hold,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int              WD_W     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX   = WD_W'(TIMEOUT);
    localparam logic [7:0]      GAP_LOAD = 8'(GAP_FRAMES);

    typedef enum logic [1:0] {IDLE, SYNC, PRESS, GAP} state_t;

    state_t          state, state_nxt;
    logic [3:0]      col_q, col_prev;
    logic [3:0]      key_q, key_nxt;
    logic            pressed, pressed_nxt;
    logic [7:0]      frame_cnt, frame_cnt_nxt;
    logic [WD_W-1:0] wd_cnt, wd_cnt_nxt, wd_inc;
    logic            done_q, done_nxt, err_q, err_nxt;
    logic            frame_start, wd_expire;

    // A frame begins when column 0 is first strobed after any other column.
    assign frame_start = (col_q == 4'b1110) && (col_prev != 4'b1110);
    assign wd_inc      = (wd_cnt == WD_MAX) ? wd_cnt : wd_cnt + 1'b1;
    assign wd_expire   = (wd_inc == WD_MAX);

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt     = state;
        key_nxt       = key_q;
        pressed_nxt   = pressed;
        frame_cnt_nxt = frame_cnt;
        wd_cnt_nxt    = wd_cnt;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;

        unique case (state)
            IDLE: begin
                wd_cnt_nxt = '0;
                if (cmd_valid) begin
                    key_nxt       = cmd_key;
                    frame_cnt_nxt = (cmd_hold == 8'd0) ? 8'd1 : cmd_hold;
                    state_nxt     = SYNC;
                end
            end
            SYNC: begin
                if (frame_start) begin
                    pressed_nxt = 1'b1;
                    state_nxt   = PRESS;
                end
            end
            PRESS: begin
                if (frame_start) begin
                    if (frame_cnt <= 8'd1) begin
                        pressed_nxt   = 1'b0;
                        frame_cnt_nxt = GAP_LOAD;
                        if (GAP_FRAMES == 0) begin
                            done_nxt  = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = GAP;
                        end
                    end else begin
                        frame_cnt_nxt = frame_cnt - 8'd1;
                    end
                end
            end
            GAP: begin
                if (frame_start) begin
                    if (frame_cnt <= 8'd1) begin
                        frame_cnt_nxt = 8'd0;
                        done_nxt      = 1'b1;
                        state_nxt     = IDLE;
                    end else begin
                        frame_cnt_nxt = frame_cnt - 8'd1;
                    end
                end
            end
        endcase

        // A frame start in the same cycle as expiry keeps the command alive.
        if (state != IDLE) begin
            if (frame_start) begin
                wd_cnt_nxt = '0;
            end else if (wd_expire) begin
                pressed_nxt   = 1'b0;
                frame_cnt_nxt = 8'd0;
                wd_cnt_nxt    = '0;
                err_nxt       = 1'b1;
                state_nxt     = IDLE;
            end else begin
                wd_cnt_nxt = wd_inc;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            col_q     <= 4'b1111;
            col_prev  <= 4'b1111;
            key_q     <= 4'd0;
            pressed   <= 1'b0;
            frame_cnt <= 8'd0;
            wd_cnt    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            col_q     <= KB_Col;
            col_prev  <= col_q;
            key_q     <= key_nxt;
            pressed   <= pressed_nxt;
            frame_cnt <= frame_cnt_nxt;
            wd_cnt    <= wd_cnt_nxt;
            done_q    <= done_nxt;
            err_q     <= err_nxt;
        end
    end

    // Single pressed key: only its row can be pulled low, and only while its
    // column is strobed, so several low columns behave like a wired-AND matrix.
    always_comb begin
        KB_Row = 4'b1111;
        if (pressed && !KB_Col[key_q[1:0]]) begin
            KB_Row[2'd3 - key_q[3:2]] = 1'b0;
        end
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_keypad_emu.sv
// Scoreboard bench for keypad_emu: a behavioural scanner reads the key matrix,
// and a monitor checks each done/err pulse against the queued expectation.
module tb_keypad_emu;

    localparam int GAP_FRAMES = 2;
    localparam int TIMEOUT    = 1024;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] KB_Col;
    logic [3:0] KB_Row;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_key;
    logic [7:0] cmd_hold;
    logic       busy;
    logic       done;
    logic       err;

    keypad_emu #(.GAP_FRAMES(GAP_FRAMES), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .KB_Col    (KB_Col),
        .KB_Row    (KB_Row),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_key   (cmd_key),
        .cmd_hold  (cmd_hold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [3:0] key;
        int         frames;
        int         gap;
        int         acc;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int evt_cnt = 0;

    // Scanner: 0 = scanning columns, 1 = idle (all high), 2 = forced value.
    int         scan_mode = 2;
    logic [3:0] force_col = 4'b0000;
    int         col_idx   = 0;
    int         frame_idx = 0;
    bit         static_mode = 1'b0;

    int seen_frames [16];
    int last_frame  [16];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic void clear_seen();
        for (int k = 0; k < 16; k++) begin
            seen_frames[k] = 0;
            last_frame[k]  = -1000;
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        logic [3:0] one_hot;
        one_hot = 4'b0001;
        forever begin
            @(posedge clk);
            #1;
            case (scan_mode)
                0: begin
                    KB_Col = ~(one_hot << col_idx);
                    if (col_idx == 0) frame_idx++;
                    col_idx = (col_idx + 1) % 4;
                end
                1:       KB_Col = 4'b1111;
                default: KB_Col = force_col;
            endcase
        end
    end

    // Monitor: record which keys the scanner reads, then score each pulse.
    always @(negedge clk) begin
        if (rst) begin
            clear_seen();
        end else begin
            if (!static_mode) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) begin
                        if (KB_Col[c] == 1'b0 && KB_Row[r] == 1'b0) begin
                            int k;
                            k = (3 - r) * 4 + c;
                            if (last_frame[k] != frame_idx) begin
                                seen_frames[k]++;
                                last_frame[k] = frame_idx;
                            end
                        end
                    end
                end
            end
            if (done || err) begin
                evt_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {30'd0, done, err}, 32'd0);
                end else begin
                    exp_t e;
                    int   all_seen;
                    e = exp_q.pop_front();
                    all_seen = 0;
                    for (int k = 0; k < 16; k++) all_seen += seen_frames[k];
                    check("event_is_err", err, e.is_err);
                    check("event_is_done", done, !e.is_err);
                    check("ready_at_event", cmd_ready, 1);
                    if (e.is_err) begin
                        check("timeout_latency", cyc - e.acc, TIMEOUT);
                        check("frames_on_timeout", seen_frames[e.key], 0);
                    end else begin
                        check("held_frames", seen_frames[e.key], e.frames);
                        check("gap_frames", frame_idx - last_frame[e.key], e.gap);
                    end
                    check("stray_keys", all_seen - seen_frames[e.key], 0);
                    clear_seen();
                end
            end
        end
    end

    // Issue one command; optionally keep cmd_valid high afterwards with another key.
    task automatic send(input logic [3:0] key, input logic [7:0] hold,
                        input bit push, input bit expect_err, input int linger);
        exp_t e;
        @(negedge clk);
        cmd_key   = key;
        cmd_hold  = hold;
        cmd_valid = 1'b1;
        for (int i = 0; i < 400 && !cmd_ready; i++) @(negedge clk);
        check("ready_wait", cmd_ready, 1);
        e.is_err = expect_err;
        e.key    = key;
        e.frames = (hold == 8'd0) ? 1 : int'(hold);
        // Columns 2 and 3 are strobed before the frame-start detector sees
        // column 0, so their last held frame is one scanner frame earlier.
        e.gap    = GAP_FRAMES + ((key[1:0] >= 2'd2) ? 1 : 0);
        e.acc    = cyc + 1;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (linger > 0) begin
            cmd_key = ~key;
            repeat (linger) @(negedge clk);
            check("ready_low_while_busy", cmd_ready, 0);
            check("busy_high", busy, 1);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", exp_q.size(), 0);
    endtask

    task automatic wait_seen(input int key);
        for (int i = 0; i < 200 && seen_frames[key] == 0; i++) @(negedge clk);
        check("key_seen", (seen_frames[key] > 0) ? 1 : 0, 1);
    endtask

    initial begin
        int e0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_key   = 4'd0;
        cmd_hold  = 8'd0;
        KB_Col    = 4'b0000;
        clear_seen();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_row", KB_Row, 4'b1111);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst       = 1'b0;
        scan_mode = 0;
        repeat (6) @(negedge clk);

        // Key 6 held 3 frames; extra cmd_valid while busy must be dropped.
        send(4'd6, 8'd3, 1'b1, 1'b0, 8);
        drain(400);

        // Hold of 0 behaves as 1.
        send(4'd12, 8'd0, 1'b1, 1'b0, 0);
        drain(400);

        // Key 9 held; probe multi-column and no-column strobes mid-press.
        send(4'd9, 8'd4, 1'b1, 1'b0, 0);
        wait_seen(9);
        scan_mode = 2;
        force_col = 4'b0000;
        @(posedge clk);
        #2 static_mode = 1'b1;
        @(negedge clk);
        check("all_cols_row", KB_Row, 4'b1101);
        force_col = 4'b1111;
        @(negedge clk);
        check("no_cols_row", KB_Row, 4'b1111);
        scan_mode   = 0;
        static_mode = 1'b0;
        drain(400);

        // All 16 keys, varied hold.
        for (int k = 0; k < 16; k++) begin
            send(4'(k), 8'((k % 3) + 1), 1'b1, 1'b0, 0);
        end
        drain(2000);

        // Scanner stalled: watchdog aborts.
        scan_mode = 1;
        repeat (6) @(negedge clk);
        send(4'd5, 8'd2, 1'b1, 1'b1, 0);
        drain(TIMEOUT + 200);
        @(negedge clk);
        check("ready_after_err", cmd_ready, 1);
        scan_mode = 0;
        repeat (6) @(negedge clk);

        // Reset during PRESS abandons the command silently.
        send(4'd3, 8'd5, 1'b0, 1'b0, 0);
        wait_seen(3);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_row", KB_Row, 4'b1111);
        check("midrst_ready", cmd_ready, 1);
        check("midrst_busy", busy, 0);
        rst = 1'b0;
        e0  = evt_cnt;
        repeat (80) @(negedge clk);
        check("no_event_after_rst", evt_cnt, e0);

        // Normal operation resumes after the abort.
        send(4'd15, 8'd2, 1'b1, 1'b0, 0);
        drain(400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/keypad_emu.md
KEYPAD_EMU -- requirements
Module: keypad_emu

Interface
REQ-001 Parameter GAP_FRAMES, default 2: scan frames the key is held released after each press before the next command is accepted.
REQ-002 Parameter TIMEOUT, default 1024: maximum clk cycles allowed between scan-frame starts while busy.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-005 Port KB_Col  input  4  column strobes from the scanner, active low.
REQ-006 Port KB_Row  output  4  emulated row lines, active low; 4'b1111 = no key.
REQ-007 Port cmd_valid  input  1  press command present.
REQ-008 Port cmd_ready  output  1  emulator can accept a command.
REQ-009 Port cmd_key  input  4  key index 0..15, in the scanner's key-vector numbering.
REQ-010 Port cmd_hold  input  8  number of full scan frames to hold the key; 0 is treated as 1.
REQ-011 Port busy  output  1  a command is in progress.
REQ-012 Port done  output  1  one-cycle pulse when a command completes normally.
REQ-013 Port err  output  1  one-cycle pulse when a command is aborted on timeout.

Function
REQ-014 Key mapping: key k sits at column c = k[1:0] and drives row bit (3 - k[3:2]), so the scanner's key[k] reads 0 while k is pressed.
REQ-015 KB_Row is combinational from KB_Col and the registered press state: a row bit is 0 iff a key is pressed, its column bit in KB_Col is 0, and that bit is the key's row bit.
REQ-016 Multiple low column bits: respond for every low column (wired-AND matrix behaviour); all-high KB_Col gives KB_Row = 4'b1111.
REQ-017 Frame start: a cycle where registered KB_Col is 4'b1110 and its previous registered value was not 4'b1110.
REQ-018 The FSM has the states IDLE, SYNC, PRESS and GAP.
REQ-019 IDLE: cmd_ready=1, busy=0; on cmd_valid&&cmd_ready, latch cmd_key and max(cmd_hold,1), then go to SYNC.
REQ-020 SYNC: key released; on a frame start, assert press, load the frame counter with the hold value, then go to PRESS.
REQ-021 PRESS: key pressed; decrement on each frame start; on the frame start that reaches 0, release the key, load GAP_FRAMES, then go to GAP.
REQ-022 GAP: key released; decrement on each frame start; at 0, pulse done, then go to IDLE.
REQ-023 If GAP_FRAMES=0, PRESS goes to IDLE with done in the same cycle it releases the key.
REQ-024 Press and release edges align to frame starts, so the key is seen for exactly the hold value of full frames.
REQ-025 Watchdog: while not IDLE, count cycles since the last frame start (reset on entering SYNC); on reaching TIMEOUT, release the key, pulse err (no done), then go to IDLE.
REQ-026 cmd_ready=0 in every state except IDLE; cmd_valid outside IDLE is ignored, with no queuing.
REQ-027 If a frame start and the watchdog expiry fall in the same cycle, the frame start wins and the watchdog clears.
REQ-028 Counters are 8-bit; the watchdog is ceil(log2(TIMEOUT+1)) bits and saturates.

Reset
REQ-029 On rst=1 at a clk edge: state IDLE, key released, counters cleared, and KB_Col history set to 4'b1111.
REQ-030 Reset output values: KB_Row=4'b1111 for any KB_Col, cmd_ready=1, busy=0, done=0, err=0.
REQ-031 Reset asserted mid-command abandons the command immediately with no done or err pulse.

Verification
REQ-032 Scanner driving 1110/1101/1011/0111 each cycle, cmd key=6, hold=3 -> row bit 2 low only while col=1011 (col 2), for exactly 3 frames, done 2 frames after release.
REQ-033 cmd key=12, hold=0 -> treated as 1; row bit 0 low during col=1110 for exactly one frame.
REQ-034 KB_Col=0000 with key 9 pressed -> KB_Row=1101; KB_Col=1111 -> KB_Row=1111.
REQ-035 KB_Col held at 1111 after a command is accepted -> err pulses after 1024 cycles; no done; cmd_ready=1 next cycle.
REQ-036 rst asserted during PRESS -> next cycle KB_Row=1111, cmd_ready=1, and no done or err pulse.
REQ-037 Loopback with the team's keypad scanner: after each command completes, the scanner's key vector shows only that key low for the held frames, for all 16 keys.
